// File: rtl/tiny_dnn_pkg.sv
// Shared constants and payload types for the bf16 input conditioner.
package tiny_dnn_pkg;

    localparam int unsigned FP32_W = 32;
    localparam int unsigned BF16_W = 16;
    localparam int unsigned LEN_W  = 12;

    localparam logic [BF16_W-1:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [7:0]        FP32_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic [BF16_W-1:0] h;
        logic              ovf;
    } bf16_t;

endpackage

// File: rtl/src_bf16_rnd_fp32_to_bf16.sv
// Combinational fp32 -> bf16 conversion: NaN canonicalisation, denormal flush,
// round-to-nearest-even (or truncation) and overflow-to-Inf detection.
module fp32_to_bf16
    import tiny_dnn_pkg::*;
(
    input  logic [FP32_W-1:0] w,
    input  logic              rnd_en,
    output logic [BF16_W-1:0] h,
    output logic              ovf
);

    logic              sgn;
    logic [7:0]        e;
    logic [22:0]       m;
    logic              is_nan;
    logic              is_den;
    logic              inc;
    logic [BF16_W-1:0] rnd_h;

    always_comb begin
        sgn    = w[31];
        e      = w[30:23];
        m      = w[22:0];
        is_nan = (e == FP32_EXP_MAX) && (m != '0);
        is_den = (e == 8'h00);
        // Guard bit set and (odd lsb or sticky): round up; ties go to even.
        inc    = rnd_en & w[15] & (w[16] | (|w[14:0]));
        rnd_h  = w[31:16] + BF16_W'(inc);
        h      = rnd_h;
        ovf    = 1'b0;
        if (is_nan) begin
            h = {sgn, BF16_QNAN[14:0]};
        end else if (is_den) begin
            h = {sgn, 15'b0};
        end else begin
            ovf = (e != FP32_EXP_MAX) && (rnd_h[14:7] == FP32_EXP_MAX);
        end
    end

endmodule

// File: rtl/src_bf16_rnd.sv
// Two-stage valid/ready stream conditioner: fp32 -> bf16 in [31:16], plus
// packet-length checking and a saturating rounding-overflow counter.
module src_bf16_rnd
    import tiny_dnn_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rnd_en,
    input  logic [LEN_W-1:0]  len,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [FP32_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [FP32_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              len_err,
    output logic [CNT_W-1:0]  ovf_cnt
);

    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic [BF16_W-1:0] s1_h_q, s1_h_d;
    logic              s1_last_q, s1_last_d;
    logic [BF16_W-1:0] s2_h_q, s2_h_d;
    logic              s2_last_q, s2_last_d;
    logic [LEN_W-1:0]  bc_q, bc_d;
    logic              len_err_q, len_err_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    logic              adv1, adv2, acc;
    logic [LEN_W:0]    bc_inc;
    logic              len_hit, len_on, err_set;
    logic [BF16_W-1:0] cvt_h;
    logic              cvt_ovf;
    bf16_t             cvt;

    fp32_to_bf16 u_cvt (
        .w      (in_data),
        .rnd_en (rnd_en),
        .h      (cvt_h),
        .ovf    (cvt_ovf)
    );

    assign cvt = '{h: cvt_h, ovf: cvt_ovf};

    // Pipeline advance, length check and counter next-state.
    always_comb begin
        adv2      = ~v2_q | out_ready;
        adv1      = ~v1_q | adv2;
        acc       = in_valid & adv1;

        v1_d      = v1_q;
        s1_h_d    = s1_h_q;
        s1_last_d = s1_last_q;
        v2_d      = v2_q;
        s2_h_d    = s2_h_q;
        s2_last_d = s2_last_q;
        bc_d      = bc_q;
        len_err_d = len_err_q;
        ovf_cnt_d = ovf_cnt_q;

        if (adv1) begin
            v1_d = acc;
            if (acc) begin
                s1_h_d    = cvt.h;
                s1_last_d = in_last;
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_h_d    = s1_h_q;
                s2_last_d = s1_last_q;
            end
        end

        bc_inc  = {1'b0, bc_q} + (LEN_W+1)'(1);
        len_hit = (bc_inc == {1'b0, len});
        len_on  = (len != '0);
        err_set = acc & len_on & (in_last ? ~len_hit : len_hit);
        if (acc) begin
            if (in_last) begin
                bc_d = '0;
            end else if (bc_q != '1) begin
                bc_d = bc_q + LEN_W'(1);
            end
        end

        // Clear first so a same-cycle error or overflow still lands.
        if (clr) begin
            len_err_d = 1'b0;
            ovf_cnt_d = '0;
        end
        if (err_set) begin
            len_err_d = 1'b1;
        end
        if (acc && cvt.ovf && (ovf_cnt_d != '1)) begin
            ovf_cnt_d = ovf_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            s1_h_q    <= '0;
            s1_last_q <= 1'b0;
            s2_h_q    <= '0;
            s2_last_q <= 1'b0;
            bc_q      <= '0;
            len_err_q <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            s1_h_q    <= s1_h_d;
            s1_last_q <= s1_last_d;
            s2_h_q    <= s2_h_d;
            s2_last_q <= s2_last_d;
            bc_q      <= bc_d;
            len_err_q <= len_err_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign out_data  = {s2_h_q, 16'h0000};
    assign out_last  = s2_last_q;
    assign len_err   = len_err_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_src_bf16_rnd.sv
// Self-checking bench for src_bf16_rnd against an arithmetic reference model.
module tb_src_bf16_rnd;

    logic        clk;
    logic        reset;
    logic        rnd_en;
    logic [11:0] len;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        len_err;
    logic [15:0] ovf_cnt;

    logic        in_ready_s, out_valid_s, out_last_s, len_err_s;
    logic [31:0] out_data_s;
    logic [3:0]  ovf_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got_d[$];
    bit          got_l[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    int          m_ovf;
    bit          m_err;
    int          m_pkt;

    src_bf16_rnd #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .rnd_en(rnd_en), .len(len), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .len_err(len_err), .ovf_cnt(ovf_cnt)
    );

    // Narrow-counter instance makes saturation reachable in a few beats.
    src_bf16_rnd #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .rnd_en(rnd_en), .len(len), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready_s),
        .out_valid(out_valid_s), .out_data(out_data_s), .out_last(out_last_s), .out_ready(out_ready),
        .len_err(len_err_s), .ovf_cnt(ovf_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference: returns {ovf, bf16}.
    function automatic logic [16:0] ref_cvt(input logic [31:0] w, input bit rnd);
        int unsigned ex, man, up, rem, res;
        bit ovf;
        ex  = (w >> 23) & 32'hFF;
        man = w & 32'h7FFFFF;
        up  = w >> 16;
        rem = w & 32'hFFFF;
        if (ex == 255 && man != 0) return {1'b0, (w[31] ? 16'hFFC0 : 16'h7FC0)};
        if (ex == 0) return {1'b0, w[31], 15'h0};
        res = up;
        if (rnd && (rem > 32'h8000 || (rem == 32'h8000 && (up % 2) == 1))) res = up + 1;
        ovf = (ex != 255) && (((res >> 7) & 32'hFF) == 255);
        return {ovf, 16'(res)};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(4))
            1: w[30:23] = 8'hFF;
            2: w[30:23] = 8'h00;
            3: begin w[30:23] = 8'hFE; w[22:16] = 7'h7F; end
            4: w[15:0] = 16'h8000;
            default: ;
        endcase
        return w;
    endfunction

    // One clock: drive, sample away from the edge, then advance.
    task automatic cycle(input bit iv, input logic [31:0] d, input bit il, input bit rnd,
                         input bit ordy, output bit acc);
        in_valid  = iv;
        in_data   = d;
        in_last   = il;
        rnd_en    = rnd;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (out_valid && ordy) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [31:0] d, input bit il, input bit rr);
        logic [16:0] m;
        m = ref_cvt(d, rr);
        exp_d.push_back({m[15:0], 16'h0000});
        exp_l.push_back(il);
        if (m[16] && m_ovf < 65535) m_ovf++;
        m_pkt++;
        if (il) begin
            if (len != 0 && m_pkt != int'(len)) m_err = 1'b1;
            m_pkt = 0;
        end
    endtask

    task automatic run_stream(input logic [31:0] w[$], input bit l[$], input bit r[$],
                              input int prob, input int budget, output int ncyc);
        int idx;
        bit acc, iv, il, rr;
        logic [31:0] d;
        idx = 0;
        ncyc = 0;
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
        while (got_d.size() < w.size() && ncyc < budget) begin
            iv = idx < w.size();
            d  = iv ? w[idx] : 32'h0;
            il = iv ? l[idx] : 1'b0;
            rr = iv ? r[idx] : 1'b0;
            cycle(iv, d, il, rr, (int'($urandom_range(99)) < prob), acc);
            ncyc++;
            if (acc) begin
                model_accept(d, il, rr);
                idx++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic clr_pulse();
        bit acc;
        clr = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        clr = 1'b0;
        m_err = 1'b0;
        m_ovf = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b exp 0", out_last); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %b exp 0", len_err); end
        n_tests++; if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_ovf_cnt: got %h exp 0", ovf_cnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rounding();
        logic [31:0] w[$];
        bit l[$], r[$];
        logic [31:0] want[6];
        int ncyc;
        want = '{32'h3F800000, 32'h3F820000, 32'h3F810000, 32'h3F800000, 32'h3F810000, 32'h3F800000};
        w = '{32'h3F808000, 32'h3F818000, 32'h3F80C000, 32'h3F808000, 32'h3F818000, 32'h3F80C000};
        l = '{0, 0, 0, 0, 0, 1};
        r = '{1, 1, 1, 0, 0, 0};
        run_stream(w, l, r, 100, 40, ncyc);
        n_tests++; if (got_d.size() != 6) begin n_fail++; $display("FAIL rnd_dir_count: got %0d exp 6", got_d.size()); end
        for (int i = 0; i < 6 && i < got_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== want[i]) begin n_fail++; $display("FAIL rnd_dir[%0d]: got %h exp %h", i, got_d[i], want[i]); end
        end
        w.delete(); l.delete(); r.delete();
        for (int i = 0; i < 60; i++) begin
            w.push_back(rand_word());
            l.push_back(i == 59 ? 1'b1 : 1'($urandom_range(1)));
            r.push_back(1'($urandom_range(1)));
        end
        run_stream(w, l, r, 100, 200, ncyc);
        n_tests++; if (got_d.size() != exp_d.size()) begin n_fail++; $display("FAIL rnd_rand_count: got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                begin n_fail++; $display("FAIL rnd_rand[%0d] in=%h: got %h/%b exp %h/%b", i, w[i], got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
        n_tests++; if (ovf_cnt !== 16'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf_cnt: got %0d exp %0d", ovf_cnt, m_ovf); end
    endtask

    task automatic test_special();
        logic [31:0] w[$];
        bit l[$], r[$];
        logic [31:0] want[4];
        int ncyc;
        clr_pulse();
        n_tests++; if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL spec_ovf_pre: got %0d exp 0", ovf_cnt); end
        want = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7F800000};
        w = '{32'h7F800001, 32'hFF800000, 32'h80400000, 32'h7F7FFFFF};
        l = '{0, 0, 0, 1};
        r = '{1, 1, 1, 1};
        run_stream(w, l, r, 100, 40, ncyc);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= got_d.size() || got_d[i] !== want[i])
                begin n_fail++; $display("FAIL special[%0d]: got %h exp %h", i, (i < got_d.size()) ? got_d[i] : 32'hx, want[i]); end
        end
        n_tests++; if (ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL spec_ovf_inc: got %0d exp 1", ovf_cnt); end
        w = '{32'h7F7FFFFF};
        l = '{1};
        r = '{0};
        run_stream(w, l, r, 100, 20, ncyc);
        n_tests++; if (got_d.size() != 1 || got_d[0] !== 32'h7F7F0000) begin n_fail++; $display("FAIL spec_trunc: got %h exp 7f7f0000", (got_d.size() > 0) ? got_d[0] : 32'hx); end
        n_tests++; if (ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL spec_ovf_hold: got %0d exp 1", ovf_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[$];
        bit l[$], r[$];
        int ncyc;
        for (int rep = 0; rep < 3; rep++) begin
            w.delete(); l.delete(); r.delete();
            for (int i = 0; i < 8; i++) begin
                w.push_back(rand_word());
                l.push_back(i == 7 ? 1'b1 : 1'($urandom_range(1)));
                r.push_back(1'($urandom_range(1)));
            end
            run_stream(w, l, r, 50, 300, ncyc);
            n_tests++; if (got_d.size() != 8) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d exp 8", rep, got_d.size()); end
            for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
                n_tests++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                    begin n_fail++; $display("FAIL bp[%0d][%0d]: got %h/%b exp %h/%b", rep, i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] wv[3];
        bit acc;
        int nacc;
        wv = '{32'h40490FDB, 32'hC02DF854, 32'h3F800000};
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, wv[nacc], nacc == 1, 1'b1, 1'b0, acc);
            if (acc) begin
                model_accept(wv[nacc], nacc == 1, 1'b1);
                nacc++;
            end
            if (c >= 1) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== exp_d[0])
                    begin n_fail++; $display("FAIL stall_hold[%0d]: got %b/%h exp 1/%h", c, out_valid, out_data, exp_d[0]); end
            end
        end
        n_tests++; if (nacc != 2) begin n_fail++; $display("FAIL stall_accepts: got %0d exp 2", nacc); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_low: got %b exp 0", in_ready); end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_rise: got %b exp 1", in_ready); end
        for (int c = 0; c < 10 && got_d.size() < 2; c++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        n_tests++; if (got_d.size() != 2) begin n_fail++; $display("FAIL stall_drain_count: got %0d exp 2", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 2; i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                begin n_fail++; $display("FAIL stall_drain[%0d]: got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
    endtask

    task automatic test_full_rate();
        logic [31:0] w[$];
        bit l[$], r[$];
        int ncyc;
        for (int i = 0; i < 8; i++) begin
            w.push_back(rand_word());
            l.push_back(i == 7);
            r.push_back(1'b1);
        end
        run_stream(w, l, r, 100, 50, ncyc);
        n_tests++; if (ncyc != 10) begin n_fail++; $display("FAIL full_rate_cycles: got %0d exp 10", ncyc); end
        n_tests++; if (got_d.size() != 8) begin n_fail++; $display("FAIL full_rate_count: got %0d exp 8", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                begin n_fail++; $display("FAIL full_rate[%0d]: got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
    endtask

    task automatic send_pkt(input int n);
        logic [31:0] w[$];
        bit l[$], r[$];
        int ncyc;
        for (int i = 0; i < n; i++) begin
            w.push_back(rand_word());
            l.push_back(i == n - 1);
            r.push_back(1'($urandom_range(1)));
        end
        run_stream(w, l, r, 100, 60, ncyc);
    endtask

    task automatic test_len();
        int sizes[5];
        bit want[5];
        sizes = '{4, 3, 5, 3, 7};
        want  = '{0, 1, 1, 0, 0};
        len = 12'd4;
        clr_pulse();
        for (int k = 0; k < 5; k++) begin
            if (k == 3) len = 12'd0;
            send_pkt(sizes[k]);
            n_tests++;
            if (len_err !== want[k] || m_err !== want[k])
                begin n_fail++; $display("FAIL len_pkt[%0d] size %0d: got %b exp %b", k, sizes[k], len_err, want[k]); end
            if (k == 1 || k == 2) begin
                clr_pulse();
                n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL len_clr[%0d]: got %b exp 0", k, len_err); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int nacc;
        len = 12'd4;
        clr_pulse();
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
        nacc = 0;
        for (int c = 0; c < 2; c++) begin
            cycle(1'b1, 32'h7F7FFFFF, 1'b0, 1'b1, 1'b0, acc);
            if (acc) begin model_accept(32'h7F7FFFFF, 1'b0, 1'b1); nacc++; end
        end
        n_tests++; if (nacc != 2 || ovf_cnt !== 16'd2) begin n_fail++; $display("FAIL rmid_pre: got %0d acc cnt %0d exp 2 acc cnt 2", nacc, ovf_cnt); end
        reset = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b exp 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b exp 1", in_ready); end
        n_tests++; if (ovf_cnt !== 16'h0 || len_err !== 1'b0) begin n_fail++; $display("FAIL rmid_counters: got %h/%b exp 0/0", ovf_cnt, len_err); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_ovf = 0; m_err = 1'b0; m_pkt = 0;
        @(posedge clk); #1;
        send_pkt(4);
        n_tests++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL rmid_len_err: got %b exp 0", len_err); end
        n_tests++; if (got_d.size() != 4) begin n_fail++; $display("FAIL rmid_count: got %0d exp 4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL rmid_data[%0d]: got %h exp %h", i, got_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_ovf_clr();
        logic [31:0] w[$];
        bit l[$], r[$];
        bit acc;
        int ncyc;
        len = 12'd0;
        clr_pulse();
        cycle(1'b1, 32'hFF7FC000, 1'b0, 1'b1, 1'b1, acc);
        if (acc) model_accept(32'hFF7FC000, 1'b0, 1'b1);
        n_tests++; if (ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_first: got %0d exp 1", ovf_cnt); end
        clr = 1'b1;
        cycle(1'b1, 32'h7F7FFFFF, 1'b1, 1'b1, 1'b1, acc);
        clr = 1'b0;
        m_ovf = 0;
        if (acc) model_accept(32'h7F7FFFFF, 1'b1, 1'b1);
        n_tests++; if (ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL ovf_clr_same: got %0d exp 1", ovf_cnt); end
        idle(4);
        for (int i = 0; i < 20; i++) begin
            w.push_back(32'h7F7F8001);
            l.push_back(i == 19);
            r.push_back(1'b1);
        end
        run_stream(w, l, r, 100, 60, ncyc);
        n_tests++; if (ovf_cnt !== 16'(m_ovf) || m_ovf != 21) begin n_fail++; $display("FAIL ovf_count: got %0d exp 21", ovf_cnt); end
        n_tests++; if (ovf_cnt_s !== 4'hF) begin n_fail++; $display("FAIL ovf_saturate: got %h exp f", ovf_cnt_s); end
    endtask

    initial begin
        reset = 1'b1; rnd_en = 1'b0; len = '0; clr = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        m_ovf = 0; m_err = 1'b0; m_pkt = 0;
        @(posedge clk); #1;
        test_reset();
        test_rounding();
        test_special();
        test_backpressure();
        test_stall();
        test_full_rate();
        test_len();
        test_reset_mid();
        test_ovf_clr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/src_bf16_rnd.md
# src_bf16_rnd

Input-side stream conditioner that sits directly upstream of the accelerator's `src_*` AXI-stream slave. It converts each incoming fp32 word to bfloat16 with round-to-nearest-even. It also canonicalises NaNs and flushes denormals to zero, and places the result in `[31:16]` so the core's 16-bit source and weight paths see correctly rounded operands. It checks packet length against an expected beat count and counts rounding overflows, with a registered 2-stage valid/ready pipeline.

## Interface
Parameters
- `CNT_W`, 16, width of the saturating overflow counter.

Ports
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rnd_en`  in  1  1 = round-to-nearest-even; 0 = truncate. Sampled per accepted beat.
- `len`  in  12  expected beats per packet; 0 disables the length check.
- `clr`  in  1  synchronous clear of `len_err` and `ovf_cnt`.
- `in_valid` / `in_data` / `in_last` / `in_ready`  in/in(32)/in/out  upstream fp32 stream.
- `out_valid` / `out_data` / `out_last` / `out_ready`  out/out(32)/out/in  to the accelerator's `src_valid` / `src_data` / `src_last` / `src_ready`.
- `len_err`  out  1  sticky packet-length error.
- `ovf_cnt`  out  `CNT_W`  saturating count of finite inputs rounded to ±Inf.

## Operation
- Conversion is applied to each accepted word `w`, with `s=w[31]`, `e=w[30:23]`, `m=w[22:0]`. Cases are listed in priority order.
  - NaN (`e==255`, `m!=0`): result `{s,15'h7FC0[14:0]}`, i.e. `7FC0`/`FFC0`.
  - Denormal or zero (`e==0`): result `{s,15'b0}`.
  - Otherwise, when `rnd_en=1`: `inc = w[15] & (w[16] | (|w[14:0]))`, result `w[31:16]+inc`. Mantissa carry propagates into the exponent. A carry reaching `e==255` yields ±Inf.
  - Otherwise, when `rnd_en=0`: result `w[31:16]`.
- Output word is `{bf16, 16'h0000}`; `out_last` equals the `in_last` of the same beat.
- `ovf_cnt` increments when an accepted beat has `e!=255` and its rounded result has exponent 255. The counter saturates at all-ones.
- Length check: the 12-bit beat counter `bc` counts accepted input beats and is active only when `len!=0`. It saturates at 4095.
  - Accepted `in_last` with `bc+1 != len` sets `len_err`; `bc` returns to 0.
  - Accepted non-last beat with `bc+1 == len` sets `len_err`; counting continues until `in_last`.
  - When `len==0`, `bc` still tracks packet boundaries but never flags.
- `clr` and a same-cycle error: set wins, and `len_err=1` next cycle. For `clr` and a same-cycle overflow, `ovf_cnt` becomes 1.

## Timing
- There are two register stages:
  - S1 holds the input word plus the `inc`, NaN, denormal and overflow decode.
  - S2 holds the output word and last.
- Latency from accepted input to `out_valid` is 2 cycles. Throughput is 1 beat/cycle when `out_ready` is held at 1.
- Advance conditions: `adv2 = ~v2 | out_ready`, `adv1 = ~v1 | adv2`, `in_ready = adv1`.
  - `in_ready` is combinational from `out_ready`. This is the only combinational in-to-out path.
- Handshake rules:
  - `out_data` and `out_last` hold stable while `out_valid & ~out_ready`.
  - `out_valid` never drops without a handshake.
- Stall: with `out_ready=0`, at most 2 beats are accepted, then `in_ready=0`. When `out_ready` rises, `in_ready` rises in the same cycle.
- `len_err` and `ovf_cnt` update at S1 load, i.e. 1 cycle after input acceptance.
- Reset values: `v1=v2=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `len_err=0`, `ovf_cnt=0`, `bc=0`; `in_ready=1`.
- Reset mid-packet discards in-flight beats; the next accepted beat is counted as beat 0.

## Structure
- Package `tiny_dnn_pkg`:
  - `BF16_QNAN=16'h7FC0`
  - `FP32_EXP_MAX=8'hFF`
  - `typedef struct packed {logic [15:0] h; logic ovf;} bf16_t`
- One combinational sub-module, `fp32_to_bf16` (`w`, `rnd_en` → `h`, `ovf`), is instantiated at the S1 input. The pipeline, counters and `len_err` live in the top.

## Test plan
- Rounding, `rnd_en=1`:
  - `3F808000` → `3F800000` (tie to even).
  - `3F818000` → `3F820000`.
  - `3F80C000` → `3F810000`.
  - Same words with `rnd_en=0` → `3F80`, `3F81`, `3F80` (upper half).
- Special values:
  - `7F800001` → `7FC00000`.
  - `FF800000` → `FF800000`.
  - `80400000` → `80000000`.
  - `7F7FFFFF` (`rnd_en=1`) → `7F800000` with `ovf_cnt` 0→1.
  - Same word with `rnd_en=0` → `7F7F0000`, counter unchanged.
- Backpressure:
  - Stream 8 beats with random `out_ready`; output order, data and last match, with no duplicates or drops.
  - `out_ready=0`: `in_ready` falls after exactly 2 acceptances.
  - Full-rate case: 8 beats complete in 10 cycles.
- Length check with `len=4`:
  - Packet of 4 (last on beat 4) → `len_err=0`.
  - Packet of 3 → `len_err=1`.
  - `clr` clears it; a packet of 5 → `len_err=1`.
  - `len=0` with any packet size → 0.
- Reset: assert `reset` while 2 beats are in flight → same cycle `out_valid=0`, `in_ready=1`, counters 0. A following 4-beat packet with `len=4` passes without error.
- `clr` coincident with overflow beat → `ovf_cnt==1` next cycle; `ovf_cnt` saturates at `FFFF` after 65536+ overflows (force-preload permitted).
